// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin arbiter sharing one regfile write port between ALU and load writeback,
// with a registered write stage forwarded to both read ports.
module regfile_wr_arbiter #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_reg,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [4:0]       b_reg,
    input  logic [WIDTH-1:0] b_data,
    output logic             RegWrite,
    output logic [4:0]       WriteRegister,
    output logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic             fwd1_valid,
    output logic [WIDTH-1:0] fwd1_data,
    output logic             fwd2_valid,
    output logic [WIDTH-1:0] fwd2_data,
    output logic             last_grant
);
    localparam logic [4:0] ZR = 5'(ZERO_REG);

    logic             we_q, we_d;
    logic [4:0]       wreg_q, wreg_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             last_q, last_d;
    logic             gnt_a, gnt_b;
    logic [4:0]       sel_reg;

    always_comb begin
        gnt_a   = a_valid && (!b_valid || last_q);
        gnt_b   = b_valid && !gnt_a;
        sel_reg = gnt_a ? a_reg : b_reg;
        last_d  = gnt_a ? 1'b0 : gnt_b ? 1'b1 : last_q;
        // Writes to the zero register are accepted but never enabled on the port.
        we_d    = (gnt_a || gnt_b) && (sel_reg != ZR);
        wreg_d  = (gnt_a || gnt_b) ? sel_reg : wreg_q;
        wdata_d = gnt_a ? a_data : gnt_b ? b_data : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            last_q  <= 1'b1;
        end else begin
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        a_ready       = gnt_a;
        b_ready       = gnt_b;
        RegWrite      = we_q;
        WriteRegister = wreg_q;
        WriteData     = wdata_q;
        last_grant    = last_q;
        fwd1_valid    = we_q && (wreg_q == ReadRegister1) && (ReadRegister1 != ZR);
        fwd2_valid    = we_q && (wreg_q == ReadRegister2) && (ReadRegister2 != ZR);
        fwd1_data     = fwd1_valid ? wdata_q : '0;
        fwd2_data     = fwd2_valid ? wdata_q : '0;
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed checks of arbitration, write stage, zero-register handling and forwarding.
module tb_regfile_wr_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [63:0] a_data, b_data;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [63:0] WriteData;
    logic [4:0]  ReadRegister1, ReadRegister2;
    logic        fwd1_valid, fwd2_valid;
    logic [63:0] fwd1_data, fwd2_data;
    logic        last_grant;
    logic [63:0] rf [32];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    regfile_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data),
        .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data),
        .last_grant(last_grant)
    );

    // External regfile the write port drives.
    always @(posedge clk) if (RegWrite) rf[WriteRegister] <= WriteData;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        a_reg = 0; b_reg = 0; a_data = 0; b_data = 0;
        ReadRegister1 = 0; ReadRegister2 = 0;
        do_reset();
        step();
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_wreg", WriteRegister, 0);
        chk("rst_wdata", WriteData, 0);
        chk("rst_last", last_grant, 1);

        do_reset();
        a_valid = 1; a_reg = 5; a_data = 64'hAA;
        #1;
        chk("a_only_ready", a_ready, 1);
        chk("a_only_bready", b_ready, 0);
        step();
        a_valid = 0;
        chk("a_only_regwrite", RegWrite, 1);
        chk("a_only_wreg", WriteRegister, 5);
        chk("a_only_wdata", WriteData, 64'hAA);
        chk("a_only_last", last_grant, 0);

        do_reset();
        a_valid = 1; b_valid = 1; a_reg = 1; b_reg = 2; a_data = 64'h11; b_data = 64'h22;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_a_ready", a_ready, (i % 2 == 0));
            chk("rr_b_ready", b_ready, (i % 2 == 1));
            step();
            chk("rr_wreg", WriteRegister, (i % 2 == 0) ? 1 : 2);
        end
        a_valid = 0; b_valid = 0;

        a_valid = 1; a_reg = 31; a_data = 64'hFF; ReadRegister1 = 31;
        #1;
        chk("zr_a_ready", a_ready, 1);
        step();
        a_valid = 0;
        #1;
        chk("zr_regwrite", RegWrite, 0);
        chk("zr_wreg", WriteRegister, 31);
        chk("zr_wdata", WriteData, 64'hFF);
        chk("zr_fwd1_valid", fwd1_valid, 0);
        chk("zr_fwd1_data", fwd1_data, 0);
        chk("zr_last", last_grant, 0);
        ReadRegister1 = 0;

        do_reset();
        a_valid = 1; b_valid = 1; a_reg = 7; b_reg = 7; a_data = 64'h1; b_data = 64'h2;
        #1;
        chk("same_a_first", a_ready, 1);
        step();
        a_valid = 0;
        chk("same_stage1", WriteData, 64'h1);
        #1;
        chk("same_b_second", b_ready, 1);
        step();
        b_valid = 0;
        chk("same_stage2", WriteData, 64'h2);
        step();
        chk("same_rf7", rf[7], 64'h2);

        a_valid = 1; a_reg = 3; a_data = 64'hDEAD;
        step();
        a_valid = 0; ReadRegister2 = 3;
        #1;
        chk("fwd2_valid", fwd2_valid, 1);
        chk("fwd2_data", fwd2_data, 64'hDEAD);
        chk("fwd1_other", fwd1_valid, 0);
        step();
        chk("fwd2_valid_gone", fwd2_valid, 0);
        chk("fwd2_data_gone", fwd2_data, 0);
        ReadRegister2 = 0;

        b_valid = 1; b_reg = 9; b_data = 64'h9;
        step();
        chk("pre_rst_last", last_grant, 1);
        a_valid = 1; a_reg = 10; a_data = 64'hA; b_reg = 11; b_data = 64'hB;
        #1;
        chk("wait_b_ready", b_ready, 0);
        rst = 1;
        step();
        rst = 0; a_valid = 0;
        chk("mid_rst_regwrite", RegWrite, 0);
        chk("mid_rst_last", last_grant, 1);
        #1;
        chk("retry_b_ready", b_ready, 1);
        step();
        b_valid = 0;
        chk("retry_regwrite", RegWrite, 1);
        chk("retry_wreg", WriteRegister, 11);
        chk("retry_wdata", WriteData, 64'hB);
        chk("retry_last", last_grant, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
